mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Contains:
  - the EX/MEM pipeline register;
  - a word-addressed data memory with a configurable wait-state count;
  - branch resolution;
  - the MEM/WB pipeline register that feeds write-back.
- Raises a stall while a load/store is in progress so upstream stages hold.

Parameters:
- DEPTH, 256: number of 32-bit words in data memory (power of two).
- ADDR_W, 8: word-address width, log2(DEPTH).
- WAIT_CYCLES, 2: extra cycles a load/store occupies the stage. 0 means a single-cycle access.

Ports:
- clock  in  1  stage clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- brachAdr  in  32  branch target from execute
- zero  in  1  ALU zero flag
- ALUres  in  32  ALU result / byte address
- reg21  in  32  store data
- writeReg  in  5  destination register
- Branch, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control bits from execute
- PCSrc  out  1  branch taken
- branchTarget  out  32  registered brachAdr
- stall  out  1  hold request to PC, IF/ID and ID/EX
- misalign  out  1  one-cycle pulse: memory op with ALUres[1:0] != 0 was dropped
- readData  out  32  MEM/WB load data
- aluResOut  out  32  MEM/WB ALU result
- writeRegOut  out  5  MEM/WB destination register
- RegWriteOut, MemtoRegOut  out  1 each  MEM/WB control bits

Behaviour:
- Reset:
  - Clears EX/MEM and MEM/WB registers to all zero, which is a bubble.
  - FSM goes to IDLE, counter cnt to 0.
  - All outputs read 0 the cycle after reset is sampled.
  - Memory contents are not cleared.
- EX/MEM register:
  - Captures all inputs on each edge when stall=0.
  - Holds its contents when stall=1.
- Derived signals from the EX/MEM register:
  - memop = MemRead_q | MemWrite_q.
  - addr = ALUres_q[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH.
- Branch:
  - PCSrc = Branch_q & zero_q, combinational from EX/MEM and not gated by stall.
  - branchTarget = brachAdr_q.
- FSM:
  - IDLE:
    - If memop and aligned and WAIT_CYCLES > 0: stall=1, cnt increments, and the FSM goes to WAIT at the edge.
    - Otherwise the op completes this cycle.
  - WAIT: stall=1 while cnt < WAIT_CYCLES.
    - On the cycle where cnt == WAIT_CYCLES: stall=0, the op completes, cnt returns to 0, and the FSM returns to IDLE.
  - Timing: a memop occupies WAIT_CYCLES+1 cycles, with stall high for the first WAIT_CYCLES of them.
- Completion edge:
  - Store: mem[addr] <= reg21_q.
  - Load: readData <= mem[addr], old contents.
  - MEM/WB captures aluResOut, writeRegOut, RegWriteOut and MemtoRegOut from EX/MEM.
  - Non-memop instructions take this completion path every cycle.
- While stall=1, MEM/WB captures a bubble: RegWriteOut=0 and MemtoRegOut=0. The other MEM/WB fields hold.
- MemRead_q and MemWrite_q both set:
  - The write is performed.
  - RegWriteOut forced to 0.
  - readData holds its previous value.
- Misaligned memop (ALUres_q[1:0] != 0):
  - No wait states and no memory access.
  - misalign=1 for that one cycle.
  - MEM/WB receives a bubble.
- reset asserted in WAIT:
  - Access aborted; no write commits.
  - Stall drops the cycle after.
- readData for a non-load: holds its previous value. Write-back uses it only when MemtoRegOut=1.

Decomposition:
- Shared package (mips_pkg):
  - FSM state enum: MEM_IDLE, MEM_WAIT.
  - Constants WORD_BYTES=4 and REG_ADDR_W=5.
- Sub-module data_mem:
  - Single-port synchronous RAM, DEPTH x 32.
  - Ports: clock, we, addr, wdata, rdata.
  - Read is asynchronous for mem_stage sampling.
  - Write takes effect at the clock edge when we=1.

Test Plan:
1. Reset, then an ALU op (RegWrite=1, ALUres=0x1234, writeReg=5), WAIT_CYCLES=2:
   - stall never rises.
   - Two edges after presentation: aluResOut=0x1234, writeRegOut=5, RegWriteOut=1, MemtoRegOut=0.
2. Store of 0xDEADBEEF at ALUres=0x10, then load from 0x10 (RegWrite=1, MemtoReg=1, writeReg=8):
   - stall high exactly 2 cycles for each op; upstream inputs are held.
   - Load yields readData=0xDEADBEEF, RegWriteOut=1, writeRegOut=8.
   - MEM/WB shows RegWriteOut=0 during stalls.
3. Branch=1, zero=1, brachAdr=0x40:
   - PCSrc=1 and branchTarget=0x40 on the cycle after capture.
   - With zero=0: PCSrc=0.
4. Load with ALUres=0x13:
   - misalign=1 for one cycle, stall=0, RegWriteOut=0, memory unchanged.
5. Store 0x55 to 0x20 with reset pulsed on the second stall cycle:
   - A subsequent load from 0x20 returns the pre-store value.
   - All outputs are 0 the cycle after reset.
6. Store with ALUres=0x400 (word address 256), DEPTH=256, then load from 0x0:
   - Load returns the stored value, confirming wrap.
   - Repeat with WAIT_CYCLES=0: stall stays 0 and each memop completes in one cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage.
//   mem_state_e : memory-access FSM states (idle / wait-state countdown)
//   WORD_BYTES  : bytes per data word
//   REG_ADDR_W  : register-file index width
package mips_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM, DEPTH x 32, single port.
//   clock : write clock
//   we    : write enable, write lands on the rising edge
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : read data, combinational from addr (old contents until the edge)
module data_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data memory with wait states,
// branch resolution and the MEM/WB register.
//   Inputs  : clock, reset (sync, active high), execute-stage results and
//             control bits (brachAdr, zero, ALUres, reg21, writeReg, Branch,
//             MemRead, MemWrite, RegWrite, MemtoReg)
//   Outputs : PCSrc/branchTarget (branch), stall (upstream hold),
//             misalign (dropped unaligned access), MEM/WB fields readData,
//             aluResOut, writeRegOut, RegWriteOut, MemtoRegOut
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           brachAdr,
  input  logic                  zero,
  input  logic [31:0]           ALUres,
  input  logic [31:0]           reg21,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic                  Branch,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  output logic                  PCSrc,
  output logic [31:0]           branchTarget,
  output logic                  stall,
  output logic                  misalign,
  output logic [31:0]           readData,
  output logic [31:0]           aluResOut,
  output logic [REG_ADDR_W-1:0] writeRegOut,
  output logic                  RegWriteOut,
  output logic                  MemtoRegOut
);

  localparam int unsigned     CNT_W    = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_CYCLES);
  localparam logic             HAS_WAIT = (WAIT_CYCLES > 0);

  // EX/MEM register
  logic [31:0]           brachAdr_q;
  logic                  zero_q;
  logic [31:0]           ALUres_q;
  logic [31:0]           reg21_q;
  logic [REG_ADDR_W-1:0] writeReg_q;
  logic                  Branch_q;
  logic                  MemRead_q;
  logic                  MemWrite_q;
  logic                  RegWrite_q;
  logic                  MemtoReg_q;

  // Access FSM
  mem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // MEM/WB register
  logic [31:0]           readData_q;
  logic [31:0]           aluResOut_q;
  logic [REG_ADDR_W-1:0] writeRegOut_q;
  logic                  RegWriteOut_q;
  logic                  MemtoRegOut_q;

  logic              memop_s;
  logic              aligned_s;
  logic              both_s;
  logic              stall_s;
  logic              complete_s;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [31:0]       rdata_s;
  logic              unused_hi_addr_s;

  assign memop_s   = MemRead_q | MemWrite_q;
  assign aligned_s = (ALUres_q[1:0] == 2'b00);
  assign both_s    = MemRead_q & MemWrite_q;
  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  assign addr_s    = ALUres_q[ADDR_W+1:2];
  assign unused_hi_addr_s = ^ALUres_q[31:ADDR_W+2];

  // Write only on the completing cycle; a reset in that cycle aborts it.
  assign we_s = complete_s & MemWrite_q & aligned_s & ~reset;

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clock (clock),
    .we    (we_s),
    .addr  (addr_s),
    .wdata (reg21_q),
    .rdata (rdata_s)
  );

  // Capture execute results unless the stage is holding.
  always_ff @(posedge clock) begin
    if (reset) begin
      brachAdr_q <= 32'h0;
      zero_q     <= 1'b0;
      ALUres_q   <= 32'h0;
      reg21_q    <= 32'h0;
      writeReg_q <= '0;
      Branch_q   <= 1'b0;
      MemRead_q  <= 1'b0;
      MemWrite_q <= 1'b0;
      RegWrite_q <= 1'b0;
      MemtoReg_q <= 1'b0;
    end else if (!stall_s) begin
      brachAdr_q <= brachAdr;
      zero_q     <= zero;
      ALUres_q   <= ALUres;
      reg21_q    <= reg21;
      writeReg_q <= writeReg;
      Branch_q   <= Branch;
      MemRead_q  <= MemRead;
      MemWrite_q <= MemWrite;
      RegWrite_q <= RegWrite;
      MemtoReg_q <= MemtoReg;
    end
  end

  // Wait-state sequencing: cnt counts the stalled cycles of the current op.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_s    = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        // Misaligned ops skip the wait states and complete (as a bubble) now.
        if (memop_s && aligned_s && HAS_WAIT) begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1'b1);
          state_d = MEM_WAIT;
        end else begin
          complete_s = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (cnt_q < WAIT_LIM) begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1'b1);
        end else begin
          complete_s = 1'b1;
          cnt_d      = '0;
          state_d    = MEM_IDLE;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: bubble while stalled or on a dropped access.
  always_ff @(posedge clock) begin
    if (reset) begin
      readData_q    <= 32'h0;
      aluResOut_q   <= 32'h0;
      writeRegOut_q <= '0;
      RegWriteOut_q <= 1'b0;
      MemtoRegOut_q <= 1'b0;
    end else if (stall_s || (memop_s && !aligned_s)) begin
      RegWriteOut_q <= 1'b0;
      MemtoRegOut_q <= 1'b0;
    end else if (complete_s) begin
      aluResOut_q   <= ALUres_q;
      writeRegOut_q <= writeReg_q;
      // A simultaneous read+write performs only the write.
      RegWriteOut_q <= RegWrite_q & ~both_s;
      MemtoRegOut_q <= MemtoReg_q;
      if (MemRead_q && !MemWrite_q) begin
        readData_q <= rdata_s;
      end
    end
  end

  assign PCSrc        = Branch_q & zero_q;
  assign branchTarget = brachAdr_q;
  assign stall        = stall_s;
  assign misalign     = memop_s & ~aligned_s;
  assign readData     = readData_q;
  assign aluResOut    = aluResOut_q;
  assign writeRegOut  = writeRegOut_q;
  assign RegWriteOut  = RegWriteOut_q;
  assign MemtoRegOut  = MemtoRegOut_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one instance with two wait states and
// one with none, each checked against a transaction-level model.
module tb_mem_stage;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] brachAdr;
    logic        zero;
    logic [31:0] ALUres;
    logic [31:0] reg21;
    logic [4:0]  writeReg;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemtoReg;
  } ins_t;

  typedef struct packed {
    logic        PCSrc;
    logic [31:0] branchTarget;
    logic        stall;
    logic        misalign;
    logic [31:0] readData;
    logic [31:0] aluResOut;
    logic [4:0]  writeRegOut;
    logic        RegWriteOut;
    logic        MemtoRegOut;
  } out_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sel0  = 1'b0;
  ins_t drv   = '0;
  ins_t in2, in0;
  out_t o2, o0, o;

  logic        p2, st2, ma2, rw2, mt2, p0, st0, ma0, rw0, mt0;
  logic [31:0] bt2, rd2, ar2, bt0, rd0, ar0;
  logic [4:0]  wr2, wr0;

  always #5 clock = ~clock;

  assign in2 = sel0 ? ins_t'('0) : drv;
  assign in0 = sel0 ? drv : ins_t'('0);
  assign o2  = {p2, bt2, st2, ma2, rd2, ar2, wr2, rw2, mt2};
  assign o0  = {p0, bt0, st0, ma0, rd0, ar0, wr0, rw0, mt0};
  assign o   = sel0 ? o0 : o2;

  mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(reset), .brachAdr(in2.brachAdr), .zero(in2.zero),
    .ALUres(in2.ALUres), .reg21(in2.reg21), .writeReg(in2.writeReg),
    .Branch(in2.Branch), .MemRead(in2.MemRead), .MemWrite(in2.MemWrite),
    .RegWrite(in2.RegWrite), .MemtoReg(in2.MemtoReg),
    .PCSrc(p2), .branchTarget(bt2), .stall(st2), .misalign(ma2),
    .readData(rd2), .aluResOut(ar2), .writeRegOut(wr2),
    .RegWriteOut(rw2), .MemtoRegOut(mt2));

  mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset), .brachAdr(in0.brachAdr), .zero(in0.zero),
    .ALUres(in0.ALUres), .reg21(in0.reg21), .writeReg(in0.writeReg),
    .Branch(in0.Branch), .MemRead(in0.MemRead), .MemWrite(in0.MemWrite),
    .RegWrite(in0.RegWrite), .MemtoReg(in0.MemtoReg),
    .PCSrc(p0), .branchTarget(bt0), .stall(st0), .misalign(ma0),
    .readData(rd0), .aluResOut(ar0), .writeRegOut(wr0),
    .RegWriteOut(rw0), .MemtoRegOut(mt0));

  // Reference model state
  logic [31:0] mmem [DEPTH];
  bit          mval [DEPTH];
  logic [31:0] m_alu, m_rd;
  logic [4:0]  m_wr;
  logic        m_rw, m_mtr;
  bit          rd_ok;
  int          cur_w;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_alu = 32'h0; m_rd = 32'h0; m_wr = 5'd0; m_rw = 1'b0; m_mtr = 1'b0;
    rd_ok = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    drv   = '0;
    tick();
    chk({tag, "_w2"}, o2, '0);
    chk({tag, "_w0"}, o0, '0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_wb(input string tag);
    chk({tag, "_alu"}, o.aluResOut, m_alu);
    chk({tag, "_wreg"}, o.writeRegOut, m_wr);
    chk({tag, "_rw"}, o.RegWriteOut, m_rw);
    chk({tag, "_mtr"}, o.MemtoRegOut, m_mtr);
    if (rd_ok) chk({tag, "_rdata"}, o.readData, m_rd);
    else       chk({tag, "_stall_after"}, o.stall, 1'b0);
  endtask

  // Present one instruction, follow it through its wait states, and check
  // branch outputs, stall length and the resulting MEM/WB contents.
  task automatic issue(input ins_t t);
    int  st;
    int  wa;
    bit  memop, mis, both;
    memop = t.MemRead | t.MemWrite;
    mis   = memop && (t.ALUres % 4 != 0);
    both  = t.MemRead & t.MemWrite;
    wa    = int'((t.ALUres / 4) % DEPTH);
    drv = t;
    tick();
    // The bubble that sat in EX/MEM has now written MEM/WB.
    m_alu = 32'h0; m_wr = 5'd0; m_rw = 1'b0; m_mtr = 1'b0;
    chk("pcsrc", o.PCSrc, t.Branch & t.zero);
    chk("btarget", o.branchTarget, t.brachAdr);
    chk("misalign", o.misalign, mis);
    st = 0;
    while (o.stall === 1'b1 && st < 40) begin
      st++;
      tick();
      chk("stall_bubble_rw", o.RegWriteOut, 1'b0);
    end
    chk("stall_cycles", st, (memop && !mis) ? cur_w : 0);
    drv = '0;
    tick();
    if (!mis) begin
      m_alu = t.ALUres;
      m_wr  = t.writeReg;
      m_rw  = t.RegWrite && !both;
      m_mtr = t.MemtoReg;
      if (t.MemRead && !both) begin
        m_rd  = mmem[wa];
        rd_ok = mval[wa];
      end
      if (t.MemWrite) begin
        mmem[wa] = t.reg21;
        mval[wa] = 1'b1;
      end
    end
    check_wb("wb");
    chk("misalign_drop", o.misalign, 1'b0);
  endtask

  function automatic ins_t rnd_ins();
    ins_t        t;
    int          k;
    logic [31:0] base;
    t = '0;
    t.brachAdr = $urandom;
    t.writeReg = 5'($urandom);
    t.reg21    = $urandom;
    base = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) * 32'd4);
    k = $urandom_range(0, 5);
    case (k)
      0: begin t.RegWrite = 1'b1; t.ALUres = $urandom; end
      1: begin t.MemRead = 1'b1; t.RegWrite = 1'b1; t.MemtoReg = 1'b1; t.ALUres = base; end
      2: begin t.MemWrite = 1'b1; t.ALUres = base; end
      3: begin t.Branch = 1'b1; t.zero = 1'($urandom); t.ALUres = $urandom; end
      4: begin
        t.MemRead  = 1'($urandom);
        t.MemWrite = ~t.MemRead;
        t.RegWrite = 1'b1;
        t.ALUres   = base | 32'($urandom_range(1, 3));
      end
      default: begin t.MemRead = 1'b1; t.MemWrite = 1'b1; t.RegWrite = 1'b1; t.ALUres = base; end
    endcase
    return t;
  endfunction

  initial begin
    ins_t t;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t t;
    for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
    cur_w = 2;
    sel0  = 1'b0;
    do_reset("reset");

    // ALU op passes straight through
    t = '0; t.RegWrite = 1'b1; t.ALUres = 32'h1234; t.writeReg = 5'd5;
    issue(t);

    // Store then load the same word
    t = '0; t.MemWrite = 1'b1; t.ALUres = 32'h10; t.reg21 = 32'hDEADBEEF;
    issue(t);
    t = '0; t.MemRead = 1'b1; t.RegWrite = 1'b1; t.MemtoReg = 1'b1;
    t.ALUres = 32'h10; t.writeReg = 5'd8;
    issue(t);
    chk("load_deadbeef", o.readData, 32'hDEADBEEF);

    // Branch taken / not taken
    t = '0; t.Branch = 1'b1; t.zero = 1'b1; t.brachAdr = 32'h40;
    issue(t);
    t.zero = 1'b0;
    issue(t);

    // Misaligned load is dropped
    t = '0; t.MemRead = 1'b1; t.RegWrite = 1'b1; t.ALUres = 32'h13;
    issue(t);
    t = '0; t.MemRead = 1'b1; t.ALUres = 32'h10;
    issue(t);
    chk("misalign_mem_kept", o.readData, 32'hDEADBEEF);

    // Store aborted by reset on its second stall cycle
    t = '0; t.MemWrite = 1'b1; t.ALUres = 32'h20; t.reg21 = 32'hA5A50001;
    issue(t);
    t = '0; t.MemWrite = 1'b1; t.ALUres = 32'h20; t.reg21 = 32'h55;
    drv = t;
    tick();
    chk("abort_stall1", o.stall, 1'b1);
    tick();
    chk("abort_stall2", o.stall, 1'b1);
    do_reset("abort_reset");
    t = '0; t.MemRead = 1'b1; t.RegWrite = 1'b1; t.MemtoReg = 1'b1;
    t.ALUres = 32'h20; t.writeReg = 5'd3;
    issue(t);
    chk("abort_prestore", o.readData, 32'hA5A50001);

    // Address wrap: word 256 aliases word 0
    t = '0; t.MemWrite = 1'b1; t.ALUres = 32'h400; t.reg21 = 32'h0BADF00D;
    issue(t);
    t = '0; t.MemRead = 1'b1; t.RegWrite = 1'b1; t.MemtoReg = 1'b1; t.ALUres = 32'h0;
    issue(t);
    chk("wrap_w2", o.readData, 32'h0BADF00D);

    for (int i = 0; i < 40; i++) issue(rnd_ins());

    // Same checks on the zero-wait-state instance
    sel0  = 1'b1;
    cur_w = 0;
    for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
    do_reset("reset0");
    t = '0; t.MemWrite = 1'b1; t.ALUres = 32'h400; t.reg21 = 32'h13579BDF;
    issue(t);
    t = '0; t.MemRead = 1'b1; t.RegWrite = 1'b1; t.MemtoReg = 1'b1; t.ALUres = 32'h0;
    issue(t);
    chk("wrap_w0", o.readData, 32'h13579BDF);

    for (int i = 0; i < 40; i++) issue(rnd_ins());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
